// File: rtl/rsa_byte_loader_pkg.sv
// Shared definitions for the RSA byte loader: state encoding, default key width
// and the byte-counter width helper.
package rsa_byte_loader_pkg;

  localparam int RSA_KEY_W = 256;

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_START = 3'd1,
    S_ARM   = 3'd2,
    S_WAIT  = 3'd3,
    S_SEND  = 3'd4
  } state_t;

  // Counter must span all three operands during load.
  function automatic int byteCntWidth(input int nbytes);
    return $clog2(3 * nbytes);
  endfunction

endpackage

// File: rtl/rsa_byte_loader_shreg.sv
// KEY_W-wide register that either loads in parallel or shifts left by one byte,
// inserting the new byte at the LSB end.
module rsa_byte_shreg
  import rsa_byte_loader_pkg::*;
#(
  parameter int W = RSA_KEY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_loadData,
  input  logic         i_shift,
  input  logic [7:0]   i_shiftIn,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Parallel load wins over shift if both are ever asserted together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_loadData;
    end else if (i_shift) begin
      r_q <= {r_q[W-9:0], i_shiftIn};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/rsa_byte_loader.sv
// Byte-serial host front end for the Montgomery exponentiator: loads N, e, M,
// pulses start, waits for completion and streams A1 back out MSB first.
// Optional watchdog enabled by defining RSA_LOADER_TIMEOUT_EN.
module rsa_byte_loader
  import rsa_byte_loader_pkg::*;
#(
  parameter int KEY_W       = RSA_KEY_W,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             me_start,
  output logic [KEY_W-1:0] me_N,
  output logic [KEY_W-1:0] me_e,
  output logic [KEY_W-1:0] me_M,
  input  logic             me_ready,
  input  logic [KEY_W-1:0] me_A1,
  output logic             busy,
  output logic             err
);

  localparam int NBYTES = KEY_W / 8;
  localparam int CW     = byteCntWidth(NBYTES);

  localparam logic [CW-1:0] LAST_IN  = CW'(3 * NBYTES - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(NBYTES - 1);
  localparam logic [CW-1:0] E_BASE   = CW'(NBYTES);
  localparam logic [CW-1:0] M_BASE   = CW'(2 * NBYTES);

  if ((KEY_W % 8) != 0 || KEY_W < 16 || TIMEOUT_CYC < 2) begin : g_paramCheck
    $error("rsa_byte_loader: KEY_W must be a multiple of 8 (>=16) and TIMEOUT_CYC >= 2");
  end

  state_t           r_state;
  state_t           w_nextState;
  logic [CW-1:0]    r_byteCnt;
  logic             w_inFire;
  logic             w_outFire;
  logic             w_capture;
  logic             w_shiftN;
  logic             w_shiftE;
  logic             w_shiftM;
  logic             w_timeout;
  logic [KEY_W-1:0] w_result;

`ifdef RSA_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] r_toCnt;
  logic          r_err;

  // Counter spans both S_ARM and S_WAIT so a stuck-high or stuck-low ready
  // are both caught within one budget.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_toCnt <= '0;
    end else if (r_state == S_ARM || r_state == S_WAIT) begin
      r_toCnt <= r_toCnt + TW'(1);
    end else begin
      r_toCnt <= '0;
    end
  end

  assign w_timeout = (r_toCnt == TO_LAST) &&
                     ((r_state == S_ARM && me_ready) || (r_state == S_WAIT && !me_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end else if (w_inFire) begin
      r_err <= 1'b0;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_nextState;
    end
  end

  // S_ARM exists because the core holds ready high through preprocessing;
  // only a fall then a rise marks a genuine completion.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_LOAD:  if (w_inFire && r_byteCnt == LAST_IN) w_nextState = S_START;
      S_START: w_nextState = S_ARM;
      S_ARM:   if (!me_ready) w_nextState = S_WAIT;
               else if (w_timeout) w_nextState = S_LOAD;
      S_WAIT:  if (me_ready) w_nextState = S_SEND;
               else if (w_timeout) w_nextState = S_LOAD;
      S_SEND:  if (w_outFire && r_byteCnt == LAST_OUT) w_nextState = S_LOAD;
      default: w_nextState = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    me_start  = 1'b0;
    busy      = 1'b1;
    w_capture = 1'b0;
    case (r_state)
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_START: me_start  = 1'b1;
      S_WAIT:  w_capture = me_ready;
      S_SEND:  out_valid = 1'b1;
      default: ;
    endcase
  end

  assign w_inFire  = in_valid && in_ready;
  assign w_outFire = out_valid && out_ready;
  assign w_shiftN  = w_inFire && (r_byteCnt < E_BASE);
  assign w_shiftE  = w_inFire && (r_byteCnt >= E_BASE) && (r_byteCnt < M_BASE);
  assign w_shiftM  = w_inFire && (r_byteCnt >= M_BASE);
  assign out_data  = w_result[KEY_W-1 -: 8];

  // One counter serves both the load and send phases; it is idle otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byteCnt <= '0;
    end else begin
      case (r_state)
        S_LOAD:
          if (w_inFire) r_byteCnt <= (r_byteCnt == LAST_IN) ? '0 : r_byteCnt + CW'(1);
        S_WAIT:
          if (w_capture) r_byteCnt <= '0;
        S_SEND:
          if (w_outFire) r_byteCnt <= (r_byteCnt == LAST_OUT) ? '0 : r_byteCnt + CW'(1);
        default: ;
      endcase
      if (w_timeout) r_byteCnt <= '0;
    end
  end

  rsa_byte_shreg #(.W(KEY_W)) u_regN (
    .clk        (clk),
    .rst        (rst),
    .i_load     (1'b0),
    .i_loadData ('0),
    .i_shift    (w_shiftN),
    .i_shiftIn  (in_data),
    .o_q        (me_N)
  );

  rsa_byte_shreg #(.W(KEY_W)) u_regE (
    .clk        (clk),
    .rst        (rst),
    .i_load     (1'b0),
    .i_loadData ('0),
    .i_shift    (w_shiftE),
    .i_shiftIn  (in_data),
    .o_q        (me_e)
  );

  rsa_byte_shreg #(.W(KEY_W)) u_regM (
    .clk        (clk),
    .rst        (rst),
    .i_load     (1'b0),
    .i_loadData ('0),
    .i_shift    (w_shiftM),
    .i_shiftIn  (in_data),
    .o_q        (me_M)
  );

  rsa_byte_shreg #(.W(KEY_W)) u_regResult (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_capture),
    .i_loadData (me_A1),
    .i_shift    (w_outFire),
    .i_shiftIn  (8'h00),
    .o_q        (w_result)
  );

endmodule
